// File: rtl/tetris_input_conditioner_if.sv
// tetris_input_conditioner_if: raw push-button levels in, conditioned game commands out
interface tetris_input_conditioner_if;
   logic       left_i;
   logic       right_i;
   logic       rotate_i;
   logic       start_i;
   logic       left_o;
   logic       right_o;
   logic       rotate_o;
   logic       start_o;
   logic [3:0] held_o;
   modport master (
      output left_i, right_i, rotate_i, start_i,
      input  left_o, right_o, rotate_o, start_o, held_o
   );
   modport slave (
      input  left_i, right_i, rotate_i, start_i,
      output left_o, right_o, rotate_o, start_o, held_o
   );
endinterface

// File: rtl/tetris_input_conditioner.sv
// tetris_input_conditioner: sync, debounce and pulse four buttons; left/right hold-to-repeat when TETRIS_AUTOREPEAT_EN is defined
module tetris_input_conditioner #(
   parameter int debounce_cycles_p = 10000,
   parameter int repeat_delay_p    = 200000,
   parameter int repeat_rate_p     = 50000
) (
   input logic                       clk_i,
   input logic                       reset_n_i,
   tetris_input_conditioner_if.slave bus
);
   localparam int cw_lp = $clog2(debounce_cycles_p);
   localparam logic [cw_lp-1:0] cnt_last_lp = cw_lp'(debounce_cycles_p - 1);

   // timing parameters below 2 would collapse the terminal counts onto the reset value
   if (debounce_cycles_p < 2 || repeat_delay_p < 2 || repeat_rate_p < 2) begin : g_bad_param
      $error("tetris_input_conditioner: timing parameters must be >= 2");
   end

   // channel order everywhere: {start, rotate, right, left}
   logic [3:0]       raw;
   logic [3:0]       s1_q, s1_d;
   logic [3:0]       s2_q, s2_d;
   logic [3:0]       db_q, db_d;
   logic [3:0]       rise;
   logic [3:0]       pulse_q, pulse_d;
   logic [cw_lp-1:0] cnt_q [4];
   logic [cw_lp-1:0] cnt_d [4];

   assign raw = {bus.start_i, bus.rotate_i, bus.right_i, bus.left_i};

   // two-flop synchroniser feeding a stability counter; db only follows s2 after N agreeing cycles
   always_comb begin
      s1_d = raw;
      s2_d = s1_q;
      for (int i = 0; i < 4; i++) begin
         db_d[i]  = db_q[i];
         cnt_d[i] = '0;
         rise[i]  = 1'b0;
         if (s2_q[i] != db_q[i]) begin
            if (cnt_q[i] == cnt_last_lp) begin
               db_d[i] = s2_q[i];
               rise[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // synchroniser, debounce and command pulse registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         s1_q    <= '0;
         s2_q    <= '0;
         db_q    <= '0;
         cnt_q   <= '{default: '0};
         pulse_q <= '0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

`ifdef TETRIS_AUTOREPEAT_EN
   localparam int tmax_lp = (repeat_delay_p > repeat_rate_p) ? repeat_delay_p : repeat_rate_p;
   localparam int tw_lp   = $clog2(tmax_lp);
   localparam logic [tw_lp-1:0] delay_last_lp = tw_lp'(repeat_delay_p - 1);
   localparam logic [tw_lp-1:0] rate_last_lp  = tw_lp'(repeat_rate_p - 1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;

   rep_state_e       st_q [2];
   rep_state_e       st_d [2];
   logic [tw_lp-1:0] t_q [2];
   logic [tw_lp-1:0] t_d [2];
   logic [1:0]       rep;
   logic             conflict;

   // repeat timers; using the incoming db level means a release edge or a second key never fires a repeat
   always_comb begin
      conflict = db_d[0] & db_d[1];
      for (int i = 0; i < 2; i++) begin
         st_d[i] = st_q[i];
         t_d[i]  = t_q[i] + 1'b1;
         rep[i]  = 1'b0;
         if (conflict || !db_d[i]) begin
            st_d[i] = IDLE;
            t_d[i]  = '0;
         end else if (st_q[i] == IDLE) begin
            st_d[i] = rise[i] ? DELAY : IDLE;
            t_d[i]  = '0;
         end else if (t_q[i] == ((st_q[i] == DELAY) ? delay_last_lp : rate_last_lp)) begin
            st_d[i] = REPEAT;
            t_d[i]  = '0;
            rep[i]  = 1'b1;
         end
      end
   end

   // autorepeat state and timer registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         st_q <= '{default: IDLE};
         t_q  <= '{default: '0};
      end else begin
         st_q <= st_d;
         t_q  <= t_d;
      end
   end

   assign pulse_d = rise | {2'b00, rep};
`else
   assign pulse_d = rise;
`endif

   assign bus.left_o   = pulse_q[0];
   assign bus.right_o  = pulse_q[1];
   assign bus.rotate_o = pulse_q[2];
   assign bus.start_o  = pulse_q[3];
   assign bus.held_o   = db_q;
endmodule

// File: tb/tb_tetris_input_conditioner.sv
// tb_tetris_input_conditioner: directed checks with N=4, D=10, R=3; expectations follow TETRIS_AUTOREPEAT_EN
module tb_tetris_input_conditioner;
`ifdef TETRIS_AUTOREPEAT_EN
   localparam bit ar_lp = 1'b1;
`else
   localparam bit ar_lp = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   tetris_input_conditioner_if bus ();

   tetris_input_conditioner #(
      .debounce_cycles_p(4),
      .repeat_delay_p   (10),
      .repeat_rate_p    (3)
   ) dut (
      .clk_i    (clk),
      .reset_n_i(rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      bus.left_i = 1'b1; bus.right_i = 1'b1; bus.rotate_i = 1'b1; bus.start_i = 1'b1;
      rst_n = 1'b0;
      step(3);
      vectors++;
      if ({bus.left_o, bus.right_o, bus.rotate_o, bus.start_o, bus.held_o} !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_outputs got %b%b%b%b held %b, expected all 0", bus.left_o, bus.right_o, bus.rotate_o, bus.start_o, bus.held_o);
      end
      bus.left_i = 1'b0; bus.right_i = 1'b0; bus.start_i = 1'b0;
      rst_n = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         step(1);
         vectors++;
         if (bus.rotate_o !== (c == 6)) begin
            miscompares++;
            $display("FAIL rotate_latency edge k+%0d got %b expected %b", c - 1, bus.rotate_o, c == 6);
         end
         vectors++;
         if (bus.held_o !== ((c >= 6) ? 4'b0100 : 4'b0000)) begin
            miscompares++;
            $display("FAIL rotate_held edge k+%0d got %b", c - 1, bus.held_o);
         end
      end
      bus.rotate_i = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         step(1);
         vectors++;
         if (bus.rotate_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rotate_release cycle %0d got %b expected 0", c, bus.rotate_o);
         end
      end
      vectors++;
      if (bus.held_o !== 4'b0000) begin
         miscompares++;
         $display("FAIL rotate_held_fall got %b expected 0000", bus.held_o);
      end
   endtask

   task automatic test_bounce;
      for (int c = 0; c < 24; c++) begin
         bus.left_i = (c < 8) ? ((c / 2) % 2 == 0) : 1'b0;
         step(1);
         vectors++;
         if (bus.left_o !== 1'b0 || bus.held_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce cycle %0d left_o %b held %b expected 0", c, bus.left_o, bus.held_o[0]);
         end
      end
   endtask

   task automatic test_autorepeat;
      logic exp;
      bus.left_i = 1'b1;
      for (int n = 0; n < 20 && bus.left_o !== 1'b1; n++) step(1);
      vectors++;
      if (bus.left_o !== 1'b1 || bus.held_o[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL autorepeat_press left_o %b held %b expected 1 1", bus.left_o, bus.held_o[0]);
      end
      for (int c = 1; c <= 60; c++) begin
         if (c == 40) bus.left_i = 1'b0;
         step(1);
         exp = ar_lp && c >= 10 && c < 45 && ((c - 10) % 3 == 0);
         vectors++;
         if (bus.left_o !== exp) begin
            miscompares++;
            $display("FAIL autorepeat P+%0d left_o %b expected %b", c, bus.left_o, exp);
         end
         vectors++;
         if (bus.held_o[0] !== (c < 45)) begin
            miscompares++;
            $display("FAIL autorepeat_held P+%0d got %b expected %b", c, bus.held_o[0], c < 45);
         end
      end
   endtask

   task automatic test_early_release;
      int pulses;
      pulses = 0;
      bus.right_i = 1'b1;
      for (int n = 0; n < 20 && bus.held_o[1] !== 1'b1; n++) step(1);
      if (bus.right_o === 1'b1) pulses++;
      for (int c = 1; c <= 30; c++) begin
         if (c == 4) bus.right_i = 1'b0;
         step(1);
         if (bus.right_o === 1'b1) pulses++;
      end
      vectors++;
      if (pulses != 1) begin
         miscompares++;
         $display("FAIL early_release right_o pulses %0d expected 1", pulses);
      end
      vectors++;
      if (bus.held_o !== 4'b0000) begin
         miscompares++;
         $display("FAIL early_release_held got %b expected 0000", bus.held_o);
      end
   endtask

   task automatic test_conflict;
      bus.left_i = 1'b1;
      for (int n = 0; n < 20 && bus.left_o !== 1'b1; n++) step(1);
      vectors++;
      if (bus.left_o !== 1'b1) begin
         miscompares++;
         $display("FAIL conflict_left_press got %b expected 1", bus.left_o);
      end
      for (int c = 1; c <= 12; c++) begin
         step(1);
         vectors++;
         if (bus.left_o !== (ar_lp && c == 10)) begin
            miscompares++;
            $display("FAIL conflict_left_repeat P+%0d got %b expected %b", c, bus.left_o, ar_lp && c == 10);
         end
      end
      bus.right_i = 1'b1;
      for (int n = 0; n < 20 && bus.right_o !== 1'b1; n++) step(1);
      vectors++;
      if (bus.right_o !== 1'b1 || bus.left_o !== 1'b0 || bus.held_o[1:0] !== 2'b11) begin
         miscompares++;
         $display("FAIL conflict_right_press right_o %b left_o %b held %b expected 1 0 11", bus.right_o, bus.left_o, bus.held_o[1:0]);
      end
      for (int c = 1; c <= 30; c++) begin
         step(1);
         vectors++;
         if (bus.left_o !== 1'b0 || bus.right_o !== 1'b0) begin
            miscompares++;
            $display("FAIL conflict_both_held cycle %0d left_o %b right_o %b expected 0 0", c, bus.left_o, bus.right_o);
         end
      end
      bus.right_i = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         step(1);
         vectors++;
         if (bus.left_o !== 1'b0 || bus.right_o !== 1'b0) begin
            miscompares++;
            $display("FAIL conflict_after_release cycle %0d left_o %b right_o %b expected 0 0", c, bus.left_o, bus.right_o);
         end
      end
      vectors++;
      if (bus.held_o[1:0] !== 2'b01) begin
         miscompares++;
         $display("FAIL conflict_held got %b expected 01", bus.held_o[1:0]);
      end
      bus.left_i = 1'b0;
      step(10);
   endtask

   task automatic test_reset_mid_repeat;
      bus.left_i = 1'b1;
      for (int n = 0; n < 20 && bus.held_o[0] !== 1'b1; n++) step(1);
      step(11);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.held_o !== 4'b0000 || bus.left_o !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset held %b left_o %b expected 0000 0", bus.held_o, bus.left_o);
      end
      #2 rst_n = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         step(1);
         vectors++;
         if (bus.left_o !== (c == 6)) begin
            miscompares++;
            $display("FAIL reset_fresh_press edge k+%0d left_o %b expected %b", c - 1, bus.left_o, c == 6);
         end
      end
      bus.left_i = 1'b0;
      step(10);
   endtask

   task automatic test_start;
      bus.start_i = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         step(1);
         vectors++;
         if (bus.start_o !== (c == 6) || bus.held_o[3] !== (c >= 6)) begin
            miscompares++;
            $display("FAIL start edge k+%0d start_o %b held %b expected %b %b", c - 1, bus.start_o, bus.held_o[3], c == 6, c >= 6);
         end
      end
      bus.start_i = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         step(1);
         vectors++;
         if (bus.start_o !== 1'b0) begin
            miscompares++;
            $display("FAIL start_release cycle %0d got %b expected 0", c, bus.start_o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_autorepeat();
      test_early_release();
      test_conflict();
      test_reset_mid_repeat();
      test_start();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
